// File: rtl/elevator_call_scheduler_if.sv
// Call-button / elevator-FSM bundle for the call scheduler.
// The master drives the buttons and car status. The scheduler sits on the slave side.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 8
);
    logic [NUM_FLOORS-1:0] call_btn;
    logic [3:0]            current_floor;
    logic                  idle;
    logic [3:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  busy;

    modport master (
        output call_btn, current_floor, idle,
        input  requested_floor, pending, dir_up, busy
    );

    modport slave (
        input  call_btn, current_floor, idle,
        output requested_floor, pending, dir_up, busy
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Call-button synchroniser/debouncer, pending-call latch and SCAN sweep scheduler
// that feeds requested_floor to the elevator FSM.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS      = 8,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    elevator_call_scheduler_if.slave bus
);
    localparam logic [31:0] TICK_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  TOP_FLOOR = 4'(NUM_FLOORS - 1);
    localparam logic [3:0]  FLOOR_LIM = 4'(NUM_FLOORS);

    typedef enum logic [1:0] {HOLD, UP, DOWN} state_t;

    logic [31:0]           tick_cnt_reg;
    logic                  tick;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pending_reg;
    logic [NUM_FLOORS-1:0] pending_next;
    state_t                state_reg;
    logic [3:0]            requested_floor_reg;
    logic                  dir_up_reg;
    logic                  busy_reg;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 32'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
            logic [1:0] sync_reg;
            logic [1:0] sample_reg;
            logic       level_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg   <= '0;
                    sample_reg <= '0;
                    level_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[0], bus.call_btn[gi]};
                    if (tick) begin
                        sample_reg <= {sample_reg[0], sync_reg[1]};
                    end
                    if (sample_reg == 2'b11) begin
                        level_reg <= 1'b1;
                    end else if (sample_reg == 2'b00) begin
                        level_reg <= 1'b0;
                    end
                end
            end

            // One-cycle event as the debounced level is about to rise.
            assign press[gi] = (sample_reg == 2'b11) && !level_reg;

            // Clearing at the idle floor overrides a simultaneous press.
            assign pending_next[gi] = (pending_reg[gi] | press[gi]) &
                                      ~(bus.idle && (bus.current_floor == 4'(gi)));
        end
    endgenerate

    logic       any_above;
    logic       any_below;
    logic [3:0] up_target;
    logic [3:0] down_target;
    logic [3:0] hold_floor;
    logic       go_up;
    logic       go_down;

    // Descending scan leaves the lowest hit in up_target; ascending scan leaves the highest in down_target.
    always_comb begin
        any_above   = 1'b0;
        any_below   = 1'b0;
        up_target   = '0;
        down_target = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending_reg[f] && (4'(f) >= bus.current_floor)) begin
                any_above = 1'b1;
                up_target = 4'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_reg[f] && (4'(f) <= bus.current_floor)) begin
                any_below   = 1'b1;
                down_target = 4'(f);
            end
        end
    end

    assign hold_floor = (bus.current_floor >= FLOOR_LIM) ? TOP_FLOOR : bus.current_floor;

    // DOWN keeps sweeping down while it can; HOLD and UP prefer going up.
    always_comb begin
        go_up   = 1'b0;
        go_down = 1'b0;
        if (state_reg == DOWN) begin
            go_down = any_below;
            go_up   = !any_below && any_above;
        end else begin
            go_up   = any_above;
            go_down = !any_above && any_below;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg         <= '0;
            state_reg           <= HOLD;
            requested_floor_reg <= '0;
            dir_up_reg          <= 1'b0;
            busy_reg            <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (go_up) begin
                state_reg           <= UP;
                requested_floor_reg <= up_target;
                dir_up_reg          <= 1'b1;
                busy_reg            <= 1'b1;
            end else if (go_down) begin
                state_reg           <= DOWN;
                requested_floor_reg <= down_target;
                dir_up_reg          <= 1'b0;
                busy_reg            <= 1'b1;
            end else begin
                state_reg           <= HOLD;
                requested_floor_reg <= hold_floor;
                dir_up_reg          <= 1'b0;
                busy_reg            <= 1'b0;
            end
        end
    end

    assign bus.pending         = pending_reg;
    assign bus.requested_floor = requested_floor_reg;
    assign bus.dir_up          = dir_up_reg;
    assign bus.busy            = busy_reg;
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request side of the elevator controller. It takes raw hall/car call buttons and synchronises and debounces them. It latches them as pending calls and runs a SCAN (up/down sweep) scheduler that drives `requested_floor` into the elevator state machine. Calls clear automatically when the elevator reports idle at the called floor. It sits between the `ui_in` button pins and the elevator FSM, and also drives call-lamp outputs.

## Interface
- `NUM_FLOORS`, 8: number of served floors, 2..10; floors are 0..NUM_FLOORS-1.
- `DEBOUNCE_CYCLES`, 100000: clk cycles between debounce sample ticks, ≥2; counter width 32 bits.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `call_btn`  in  NUM_FLOORS  raw asynchronous buttons; bit f = call to floor f, active-high.
- `current_floor`  in  4  floor reported by the elevator FSM.
- `idle`  in  1  elevator idle/doors-open indication from the FSM.
- `requested_floor`  out  4  target floor to the elevator FSM; registered.
- `pending`  out  NUM_FLOORS  latched calls; also drives call lamps; registered.
- `dir_up`  out  1  1 when the scheduler is in state UP; registered.
- `busy`  out  1  1 when the scheduler is in UP or DOWN; registered.

## Operation
- **Reset values:** `requested_floor`=0, `pending`=0, `dir_up`=0, `busy`=0, state HOLD, tick counter=0, synchroniser and sample registers=0.
- **Synchroniser:** 2-flop synchroniser per button bit.
- **Tick:** a shared counter counts 0..DEBOUNCE_CYCLES-1. `tick` pulses one cycle when the counter wraps.
- **Debounce:** on each tick, shift the synced bit into a 2-bit sample history per button. The debounced level goes to 1 when both samples are 1, and to 0 when both are 0. Otherwise it holds.
- **Press event:** a rising edge of the debounced level for floor f. A press fires once per press; holding the button does not re-fire.
- **Pending set:** a press event sets `pending[f]`.
- **Pending clear:** `pending[f]` clears when `idle`=1 and `current_floor`=f.
  - If set and clear occur in the same cycle, clear wins. A press at the floor where the elevator already sits idle is therefore never latched.
- **Scheduler FSM:** states HOLD, UP, DOWN, evaluated every cycle on the current `pending` and `current_floor`. Define:
  - A = any pending floor ≥ `current_floor`.
  - B = any pending floor ≤ `current_floor`.
- **HOLD:**
  - If A, go to UP. Else if B, go to DOWN. Otherwise stay in HOLD.
  - If both A and B, UP has priority.
- **UP:** target = lowest pending floor ≥ `current_floor`.
  - If there is none and B, go to DOWN. If there is none and not B, go to HOLD.
- **DOWN:** target = highest pending floor ≤ `current_floor`.
  - If there is none and A, go to UP. If there is none and not A, go to HOLD.
- **`requested_floor` per state:**
  - In UP or DOWN it equals the target.
  - In HOLD it equals `current_floor`, so the elevator stays put.
  - On a state transition, it takes the target computed for the new state in the same update.
- **Stopping:** a call at a floor the car is passing in the sweep direction becomes the target. The elevator FSM goes idle there, and the call clears.
- **Out-of-range floor:** if `current_floor` ≥ NUM_FLOORS, all pending floors count as "below". The FSM goes to DOWN, or holds with `requested_floor` = NUM_FLOORS-1 when nothing is pending.
- **Width rules:** floor comparisons are unsigned, 4 bits. The priority search is a fixed-order loop over NUM_FLOORS.

## Timing
- **Button to pending:**
  - 2 cycles of synchroniser delay.
  - Then a press needs two consecutive ticks sampling high. `pending[f]` rises on the clk edge after the second such tick.
  - Worst case ≈ 2·DEBOUNCE_CYCLES + 3 cycles.
- **Pending to `requested_floor`:** 1 cycle. `requested_floor`, `dir_up` and `busy` update on the edge after `pending` or `current_floor` change.
- **Clear:** `pending[f]` drops on the first edge where `idle`=1 and `current_floor`=f.
- **Glitches:** a pulse shorter than one tick period is never latched.
- **Asynchronous reset mid-operation:** clears all pending calls and debounce state immediately. `requested_floor` returns to 0.

## Test plan
- **Reset:** hold `rst_n` low → all outputs 0. Release with no buttons pressed → outputs stay 0 for 10 ticks.
- **Single call:** elevator at floor 0, idle; press floor 3 (DEBOUNCE_CYCLES=4) → `pending`=0000_1000, `requested_floor`=3, `dir_up`=1, `busy`=1. Then `current_floor`=3 with `idle`=1 → `pending`=0 and HOLD one cycle later.
- **Sweep stop:** elevator at 0; press 5, then 2 while the car is at floor 1 moving up → `requested_floor` switches 5→2. After the idle clear at floor 2, `requested_floor`=5.
- **Reversal:** at floor 4 in UP with pending {6,1} → target 6. After floor 6 clears: state DOWN, `requested_floor`=1, `dir_up`=0.
- **Debounce and same-floor press:**
  - Bounce a button high for less than one tick period, 5 times → no pending.
  - Press floor 2 while idle at floor 2 → `pending[2]` never sets.
- **Reset mid-operation:** while `pending`={3,7} and busy, pulse `rst_n` low for 1 cycle → `pending`=0, `requested_floor`=0, `busy`=0.
